uart_operand_collector: RTL and testbench



---
 rtl/uart_adder_pkg.sv | 21 ++
 rtl/uart_byte_timeout.sv | 40 ++++
 rtl/uart_operand_collector.sv | 139 +++++++++++++
 tb/tb_uart_operand_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_adder_pkg.sv
// Shared definitions for the UART-fed adder path.
// Holds the collector FSM state encoding and the frame geometry used by
// the operand collector (and later by the TX-side result serialiser).
package uart_adder_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam int BYTES_PER_FRAME = 4;

  // Index of the byte that completes a frame.
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT,
    S_HOLD    = ST_HOLD
  } state_e;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter.
// Counts enabled cycles since the last clear and saturates at the terminal
// count TIMEOUT_CYCLES-1, so it can never wrap back into a "fresh" value.
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset
//   clr_i  - clear counter to zero (wins over en_i)
//   en_i   - count this cycle
//   tc_o   - counter currently sits at the terminal count
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Idle counter: clear has priority, increment stops at the terminal count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (clr_i) begin
      cnt_r <= '0;
    end else if (en_i && (cnt_r != TC_VAL)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc_o = (cnt_r == TC_VAL);

endmodule

// File: rtl/uart_operand_collector.sv
// Assembles two 16-bit adder operands from a four-byte UART frame
// (A low, A high, B low, B high) and offers them with a valid/ack handshake.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   rx_data_i         - received byte
//   rx_valid_i        - one-cycle strobe qualifying rx_data_i
//   ack_i             - downstream consumed the operands (only used in HOLD)
//   a_o, b_o          - operands, updated only when a frame completes
//   operands_valid_o  - a_o/b_o hold a complete, unacknowledged frame
//   timeout_o         - one-cycle pulse: partial frame discarded
//   overrun_o         - one-cycle pulse: byte dropped while holding a result
module uart_operand_collector
  import uart_adder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        ack_i,
  output logic [15:0] a_o,
  output logic [15:0] b_o,
  output logic        operands_valid_o,
  output logic        timeout_o,
  output logic        overrun_o
);

  state_e      state_r;
  logic [1:0]  idx_r;
  logic [15:0] shadow_a_r;
  logic [15:0] shadow_b_r;
  logic        tmo_clr_s;
  logic        tmo_en_s;
  logic        tmo_tc_s;

  // Counter only runs while a frame is partially received; any byte restarts it.
  always_comb begin
    tmo_clr_s = 1'b1;
    tmo_en_s  = 1'b0;
    if (state_r == S_COLLECT) begin
      tmo_clr_s = rx_valid_i;
      tmo_en_s  = 1'b1;
    end else begin
      tmo_clr_s = 1'b1;
      tmo_en_s  = 1'b0;
    end
  end

  uart_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tmo_clr_s),
    .en_i  (tmo_en_s),
    .tc_o  (tmo_tc_s)
  );

  // Frame FSM with registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= S_IDLE;
      idx_r            <= 2'd0;
      shadow_a_r       <= 16'h0000;
      shadow_b_r       <= 16'h0000;
      a_o              <= 16'h0000;
      b_o              <= 16'h0000;
      operands_valid_o <= 1'b0;
      timeout_o        <= 1'b0;
      overrun_o        <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (rx_valid_i) begin
            shadow_a_r[7:0] <= rx_data_i;
            idx_r           <= 2'd1;
            state_r         <= S_COLLECT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_COLLECT: begin
          // A byte on the terminal-count cycle takes precedence over timeout.
          if (rx_valid_i) begin
            if (idx_r == LAST_IDX) begin
              shadow_b_r[15:8] <= rx_data_i;
              a_o              <= shadow_a_r;
              b_o              <= {rx_data_i, shadow_b_r[7:0]};
              operands_valid_o <= 1'b1;
              idx_r            <= 2'd0;
              state_r          <= S_HOLD;
            end else begin
              case (idx_r)
                2'd1:    shadow_a_r[15:8] <= rx_data_i;
                2'd2:    shadow_b_r[7:0]  <= rx_data_i;
                default: shadow_a_r[7:0]  <= rx_data_i;
              endcase
              idx_r <= idx_r + 2'd1;
            end
          end else if (tmo_tc_s) begin
            timeout_o <= 1'b1;
            idx_r     <= 2'd0;
            state_r   <= S_IDLE;
          end else begin
            state_r <= S_COLLECT;
          end
        end
        S_HOLD: begin
          if (ack_i) begin
            operands_valid_o <= 1'b0;
            // A byte arriving with the ack starts the next frame directly.
            if (rx_valid_i) begin
              shadow_a_r[7:0] <= rx_data_i;
              idx_r           <= 2'd1;
              state_r         <= S_COLLECT;
            end else begin
              state_r <= S_IDLE;
            end
          end else if (rx_valid_i) begin
            overrun_o <= 1'b1;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          idx_r            <= 2'd0;
          operands_valid_o <= 1'b0;
          state_r          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_operand_collector.sv
module tb_uart_operand_collector;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ack;
  logic [15:0] a;
  logic [15:0] b;
  logic        valid;
  logic        tmo_p;
  logic        ovr_p;

  uart_operand_collector #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (24)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rx_data_i        (rx_data),
    .rx_valid_i       (rx_valid),
    .ack_i            (ack),
    .a_o              (a),
    .b_o              (b),
    .operands_valid_o (valid),
    .timeout_o        (tmo_p),
    .overrun_o        (ovr_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_strobe = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int ov_cnt = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [15:0] ea, eb;
  } vec_t;
  vec_t vecs[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: a rising valid must match the oldest expected frame.
  logic prev_valid = 1'b0;
  logic prev_to    = 1'b0;
  logic prev_ov    = 1'b0;
  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_a", {16'h0, a}, {16'h0, e.a});
        check("sb_b", {16'h0, b}, {16'h0, e.b});
        check("sb_latency", cyc, e.cyc);
      end
    end
    if (tmo_p) begin
      to_cnt++;
      to_cyc = cyc;
      if (prev_to) check("timeout_width", 32'd2, 32'd1);
    end
    if (ovr_p) begin
      ov_cnt++;
      if (prev_ov) check("overrun_width", 32'd2, 32'd1);
    end
    prev_valid = valid;
    prev_to    = tmo_p;
    prev_ov    = ovr_p;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data     = d;
    rx_valid    = 1'b1;
    last_strobe = cyc;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    e.a   = ea;
    e.b   = eb;
    e.cyc = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      check("sb_wait_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, input int gap,
                            input logic [15:0] ea, eb);
    send_byte(b0); idle(gap);
    send_byte(b1); idle(gap);
    send_byte(b2); idle(gap);
    expect_frame(ea, eb);
    send_byte(b3);
    wait_sb();
  endtask

  task automatic hold_and_ack(input logic [15:0] ea, input logic [15:0] eb);
    idle(4);
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_a", {16'h0, a}, {16'h0, ea});
    check("hold_b", {16'h0, b}, {16'h0, eb});
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_clears_valid", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int base_to;
    vecs[0] = '{b0:8'h34, b1:8'h12, b2:8'h78, b3:8'h56, gap:9, ea:16'h1234, eb:16'h5678};
    vecs[1] = '{b0:8'hFF, b1:8'hFF, b2:8'h01, b3:8'h00, gap:0, ea:16'hFFFF, eb:16'h0001};
    vecs[2] = '{b0:8'hCD, b1:8'hAB, b2:8'hEF, b3:8'hBE, gap:3, ea:16'hABCD, eb:16'hBEEF};

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; ack = 1'b0;
    idle(3);
    rst = 1'b0;
    tick();
    check("rst_a", {16'h0, a}, 32'h0);
    check("rst_b", {16'h0, b}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_timeout", {31'd0, tmo_p}, 32'd0);
    check("rst_overrun", {31'd0, ovr_p}, 32'd0);

    // Table-driven frames with varying byte spacing.
    for (int i = 0; i < 3; i++) begin
      send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].gap,
                 vecs[i].ea, vecs[i].eb);
      hold_and_ack(vecs[i].ea, vecs[i].eb);
      idle(2);
    end
    check("no_timeout_in_table", to_cnt, 32'd0);

    // Timeout after a partial frame, then a clean frame.
    send_byte(8'h99);
    send_byte(8'h88);
    s = last_strobe;
    idle(TMO + 8);
    check("timeout_count", to_cnt, 32'd1);
    check("timeout_cycle", to_cyc, s + TMO + 1);
    check("timeout_no_valid", {31'd0, valid}, 32'd0);
    send_frame(8'h11, 8'h00, 8'h22, 8'h00, 1, 16'h0011, 16'h0022);

    // Overrun in HOLD, then ack coincident with the first byte of the next frame.
    send_byte(8'hAA);
    check("overrun_pulse", {31'd0, ovr_p}, 32'd1);
    check("overrun_a_kept", {16'h0, a}, 32'h0011);
    check("overrun_valid_kept", {31'd0, valid}, 32'd1);
    tick();
    check("overrun_one_cycle", {31'd0, ovr_p}, 32'd0);
    rx_data = 8'h01; rx_valid = 1'b1; ack = 1'b1;
    tick();
    rx_valid = 1'b0; ack = 1'b0;
    check("ack_byte_valid_low", {31'd0, valid}, 32'd0);
    check("ack_byte_no_overrun", {31'd0, ovr_p}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h02);
    expect_frame(16'h0001, 16'h0002);
    send_byte(8'h00);
    wait_sb();
    check("overrun_total", ov_cnt, 32'd1);
    hold_and_ack(16'h0001, 16'h0002);

    // Reset after three bytes: outputs clear and no timeout follows.
    base_to = to_cnt;
    send_byte(8'h77);
    send_byte(8'h66);
    send_byte(8'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_a", {16'h0, a}, 32'h0);
    check("midrst_b", {16'h0, b}, 32'h0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    idle(TMO + 6);
    check("midrst_no_timeout", to_cnt, base_to);
    send_frame(8'h05, 8'h00, 8'h06, 8'h00, 0, 16'h0005, 16'h0006);
    hold_and_ack(16'h0005, 16'h0006);

    // Every byte lands exactly on the terminal-count cycle.
    base_to = to_cnt;
    send_byte(8'h21); idle(TMO - 1);
    send_byte(8'h43); idle(TMO - 1);
    send_byte(8'h65); idle(TMO - 1);
    expect_frame(16'h4321, 16'h8765);
    send_byte(8'h87);
    wait_sb();
    check("terminal_no_timeout", to_cnt, base_to);
    hold_and_ack(16'h4321, 16'h8765);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
